// File: rtl/rgb_pkg.sv
// rgb_pkg: constants and types shared by the RGB keypad entry controller.
//   DIGIT_EMPTY          digit-memory code for an empty slot
//   KEY_ENTER/KEY_CLEAR  command key codes
//   ch_e                 colour channel being entered
//   state_e              entry sequencer states
package rgb_pkg;

    localparam logic [4:0] DIGIT_EMPTY = 5'd16;
    localparam logic [4:0] KEY_ENTER   = 5'd10;
    localparam logic [4:0] KEY_CLEAR   = 5'd12;

    typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_e;

    typedef enum logic [1:0] {ST_ENTRY, ST_CONV, ST_CHECK, ST_COMMIT} state_e;

endpackage

// File: rtl/bcd3_to_bin.sv
// bcd3_to_bin: combinational c*100 + d*10 + u using shift-add only.
//   c, d, u  in   hundreds, tens and units digits (0-9)
//   bin      out  10-bit binary value (0-999)
module bcd3_to_bin (
    input  logic [4:0] c,
    input  logic [4:0] d,
    input  logic [4:0] u,
    output logic [9:0] bin
);

    logic [9:0] c10, d10, u10;

    assign c10 = {5'd0, c};
    assign d10 = {5'd0, d};
    assign u10 = {5'd0, u};
    assign bin = (c10 << 6) + (c10 << 5) + (c10 << 2) + (d10 << 3) + (d10 << 1) + u10;

endmodule

// File: rtl/rgb_entry_ctrl.sv
// rgb_entry_ctrl: sequences keypad entry of R, G, B as 3-digit decimal values
module rgb_entry_ctrl
  import rgb_pkg::*;
#(
  parameter logic [4:0] KEY_ENTER_P = KEY_ENTER,
  parameter logic [4:0] KEY_CLEAR_P = KEY_CLEAR,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key,
  input  logic       key_valid,
  input  logic [4:0] mem_u,
  input  logic [4:0] mem_d,
  input  logic [4:0] mem_c,
  input  logic       mem_full,
  output logic [4:0] mem_digit,
  output logic       mem_push,
  output logic       mem_clr,
  output logic [1:0] channel,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       rgb_valid,
  output logic       err
);
  state_e state, state_nxt;
  logic init;
  logic [9:0] value10, bin;
  logic key_ok, push_ok, clear_ok, enter_ok, over, timeout;
  assign key_ok   = key_valid && state == ST_ENTRY && !init;
  assign push_ok  = key_ok && key <= 5'd9 && !mem_full;
  assign clear_ok = key_ok && key == KEY_CLEAR_P;
  assign enter_ok = key_ok && key == KEY_ENTER_P;
  assign over     = state == ST_CHECK && value10 > 10'd255;
  bcd3_to_bin u_conv (.c(mem_c), .d(mem_d), .u(mem_u), .bin(bin));
`ifdef RGB_ENTRY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] idle_cnt;
  assign timeout = state == ST_ENTRY && mem_u != DIGIT_EMPTY && !key_valid &&
                   idle_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (state != ST_ENTRY || mem_u == DIGIT_EMPTY || key_valid || timeout) ? '0 : idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ENTRY;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == ST_ENTRY ? ((enter_ok && mem_full) ? ST_CONV : ST_ENTRY) :
                state == ST_CONV  ? ST_CHECK :
                state == ST_CHECK ? (over ? ST_ENTRY : ST_COMMIT) : ST_ENTRY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init      <= 1'b1;
      channel   <= CH_R;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      value10   <= '0;
      err       <= 1'b0;
      mem_digit <= DIGIT_EMPTY;
      mem_push  <= 1'b0;
      mem_clr   <= 1'b0;
      rgb_valid <= 1'b0;
    end else begin
      init      <= 1'b0;
      mem_push  <= push_ok;
      mem_clr   <= init || timeout || clear_ok || over || state == ST_COMMIT;
      rgb_valid <= state == ST_COMMIT && channel == CH_B;
      mem_digit <= push_ok ? key : mem_digit;
      err       <= (push_ok || clear_ok) ? 1'b0 : ((enter_ok && !mem_full) || over) ? 1'b1 : err;
      value10   <= state == ST_CONV ? bin : value10;
      if (state == ST_COMMIT) begin
        r       <= (channel == CH_R || channel == 2'd3) ? value10[7:0] : r;
        g       <= channel == CH_G ? value10[7:0] : g;
        b       <= channel == CH_B ? value10[7:0] : b;
        channel <= channel == CH_G ? CH_B : channel == CH_B ? CH_R : CH_G;
      end else if (timeout) begin
        channel <= CH_R;
      end
    end
  end
endmodule
